ifid_fetch: RTL and testbench

IFID_FETCH -- requirements
Module: ifid_fetch

---
 rtl/ifid_fetch.sv | 123 ++++++++++++
 tb/tb_ifid_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_fetch.sv
// rtl/ifid_fetch.sv - instruction fetch FSM with IF/ID register and one-entry stall buffer
module ifid_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_redirect_en,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic [2:0]  o_imm_sel
);

  typedef enum logic [1:0] {BOOT, REQ, BUF} state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] buf_instr, buf_instr_nx;
  logic [31:0] buf_pc, buf_pc_nx;
  logic        valid_nx;
  logic [31:0] instr_nx, pc_nx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc  <= RESET_PC;
      buf_instr <= NOP_INSTR;
      buf_pc    <= RESET_PC;
      o_valid   <= 1'b0;
      o_instr   <= NOP_INSTR;
      o_pc      <= RESET_PC;
    end else begin
      fetch_pc  <= fetch_pc_nx;
      buf_instr <= buf_instr_nx;
      buf_pc    <= buf_pc_nx;
      o_valid   <= valid_nx;
      o_instr   <= instr_nx;
      o_pc      <= pc_nx;
    end
  end

  // Redirect overrides everything: any same-cycle ack or buffered word is dropped.
  always_comb begin
    state_nx     = state;
    fetch_pc_nx  = fetch_pc;
    buf_instr_nx = buf_instr;
    buf_pc_nx    = buf_pc;
    valid_nx     = o_valid;
    instr_nx     = o_instr;
    pc_nx        = o_pc;
    if (i_redirect_en) begin
      state_nx     = REQ;
      fetch_pc_nx  = i_redirect_pc;
      buf_instr_nx = NOP_INSTR;
      valid_nx     = 1'b0;
      instr_nx     = NOP_INSTR;
    end else begin
      case (state)
        BOOT: state_nx = REQ;
        REQ: begin
          if (i_imem_ack) begin
            fetch_pc_nx = fetch_pc + 32'd4;
            if (i_stall) begin
              buf_instr_nx = i_imem_rdata;
              buf_pc_nx    = fetch_pc;
              state_nx     = BUF;
            end else begin
              valid_nx = 1'b1;
              instr_nx = i_imem_rdata;
              pc_nx    = fetch_pc;
            end
          end else if (!i_stall) begin
            valid_nx = 1'b0;
            instr_nx = NOP_INSTR;
          end
        end
        BUF: begin
          if (!i_stall) begin
            valid_nx = 1'b1;
            instr_nx = buf_instr;
            pc_nx    = buf_pc;
            state_nx = REQ;
          end
        end
        default: state_nx = BOOT;
      endcase
    end
  end

  assign o_imem_req  = (state == REQ);
  assign o_imem_addr = fetch_pc;
  assign o_pc4       = o_pc + 32'd4;

  always_comb begin
    o_imm_sel = 3'b111;
    if (o_valid) begin
      case (o_instr[6:0])
        7'b0110111, 7'b0010111:            o_imm_sel = 3'b110;
        7'b1101111:                        o_imm_sel = 3'b010;
        7'b1100011:                        o_imm_sel = 3'b001;
        7'b0100011:                        o_imm_sel = 3'b000;
        7'b0000011, 7'b0010011, 7'b1100111: o_imm_sel = 3'b011;
        default:                           o_imm_sel = 3'b111;
      endcase
    end
  end

endmodule

// File: tb/tb_ifid_fetch.sv
// tb/tb_ifid_fetch.sv - scoreboard bench for ifid_fetch
module tb_ifid_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_redirect_en = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        o_imem_req, o_valid;
  logic [31:0] o_imem_addr, o_instr, o_pc, o_pc4;
  logic [2:0]  o_imm_sel;

  logic        ack2 = 1'b0;
  logic        tie0 = 1'b0;
  logic [31:0] tie_pc = 32'h0;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2, pc4_2;
  logic [2:0]  sel2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  sel;
  } exp_t;
  exp_t sb[$];

  always #5 i_clk = ~i_clk;

  ifid_fetch dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
    .i_redirect_en(i_redirect_en), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .o_pc4(o_pc4),
    .o_imm_sel(o_imm_sel)
  );

  ifid_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(tie0),
    .i_redirect_en(tie0), .i_redirect_pc(tie_pc),
    .o_imem_req(req2), .o_imem_addr(addr2),
    .i_imem_ack(ack2), .i_imem_rdata(i_imem_rdata),
    .o_valid(valid2), .o_instr(instr2), .o_pc(pc2), .o_pc4(pc4_2),
    .o_imm_sel(sel2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] sel);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.sel   = sel;
    sb.push_back(e);
  endtask

  // Monitor: a new IF/ID word is one that becomes valid or differs from the last one seen.
  logic        last_valid = 1'b0;
  logic [31:0] last_pc = 32'h0;
  logic [31:0] last_instr = 32'h0;
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst_n) begin
      last_valid = 1'b0;
    end else begin
      if (o_valid && (!last_valid || o_pc != last_pc || o_instr != last_instr)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h/%h expected=none", o_instr, o_pc);
        end else begin
          e = sb.pop_front();
          chk("mon_instr", o_instr, e.instr);
          chk("mon_pc", o_pc, e.pc);
          chk("mon_pc4", o_pc4, e.pc + 32'd4);
          chk("mon_imm_sel", {29'd0, o_imm_sel}, {29'd0, e.sel});
        end
      end
      last_valid = o_valid;
      last_pc    = o_pc;
      last_instr = o_instr;
    end
  end

  logic [31:0] sweep_instr [8] = '{32'h123450B7, 32'h00001097, 32'h0080006F, 32'h00000463,
                                   32'h00112023, 32'h00012083, 32'h000080E7, 32'h002081B3};
  logic [2:0]  sweep_sel   [8] = '{3'b110, 3'b110, 3'b010, 3'b001,
                                   3'b000, 3'b011, 3'b011, 3'b111};

  initial begin
    logic [31:0] a;
    step();
    step();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_instr", o_instr, NOP);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_pc4", o_pc4, 32'h4);
    chk("rst_req", {31'd0, o_imem_req}, 32'd0);
    chk("rst_imm_sel", {29'd0, o_imm_sel}, 32'd7);

    // Back-to-back fetch from address 0
    i_rst_n = 1'b1;
    step();
    chk("boot_req", {31'd0, o_imem_req}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      a = 32'(4 * i);
      chk("seq_addr", o_imem_addr, a);
      i_imem_ack   = 1'b1;
      i_imem_rdata = 32'h0000_0093 | (32'(i + 1) << 20);
      push(i_imem_rdata, a, 3'b011);
      step();
      chk("seq_valid", {31'd0, o_valid}, 32'd1);
    end
    i_imem_ack = 1'b0;
    step();
    chk("bubble_valid", {31'd0, o_valid}, 32'd0);
    chk("bubble_instr", o_instr, NOP);
    chk("bubble_imm_sel", {29'd0, o_imm_sel}, 32'd7);

    // Delayed ack: address held while waiting
    for (int k = 0; k < 3; k++) begin
      chk("wait_addr", o_imem_addr, 32'h10);
      chk("wait_req", {31'd0, o_imem_req}, 32'd1);
      chk("wait_valid", {31'd0, o_valid}, 32'd0);
      step();
    end
    chk("wait_addr_ack", o_imem_addr, 32'h10);
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h0050_0113;
    push(i_imem_rdata, 32'h10, 3'b011);
    step();
    i_imem_ack = 1'b0;
    chk("wait_next_addr", o_imem_addr, 32'h14);
    step();

    // Stall in the ack cycle: word parks in the buffer
    i_redirect_en = 1'b1;
    i_redirect_pc = 32'h8;
    step();
    i_redirect_en = 1'b0;
    chk("redir8_addr", o_imem_addr, 32'h8);
    i_stall      = 1'b1;
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h00A0_0093;
    step();
    i_imem_ack = 1'b0;
    chk("buf_req", {31'd0, o_imem_req}, 32'd0);
    chk("buf_instr_held", o_instr, NOP);
    step();
    chk("buf_req2", {31'd0, o_imem_req}, 32'd0);
    chk("buf_valid_held", {31'd0, o_valid}, 32'd0);
    step();
    chk("buf_req3", {31'd0, o_imem_req}, 32'd0);
    i_stall = 1'b0;
    push(32'h00A0_0093, 32'h8, 3'b011);
    step();
    chk("unbuf_instr", o_instr, 32'h00A0_0093);
    chk("unbuf_pc", o_pc, 32'h8);
    chk("unbuf_next_addr", o_imem_addr, 32'hC);
    chk("unbuf_req", {31'd0, o_imem_req}, 32'd1);

    // Redirect with ack and stall together
    i_imem_ack    = 1'b1;
    i_imem_rdata  = 32'hDEAD_BEEF;
    i_stall       = 1'b1;
    i_redirect_en = 1'b1;
    i_redirect_pc = 32'h100;
    step();
    i_imem_ack    = 1'b0;
    i_stall       = 1'b0;
    i_redirect_en = 1'b0;
    chk("redir_valid", {31'd0, o_valid}, 32'd0);
    chk("redir_instr", o_instr, NOP);
    chk("redir_addr", o_imem_addr, 32'h100);
    chk("redir_req", {31'd0, o_imem_req}, 32'd1);

    // Redirect out of BUF discards the parked word
    i_stall      = 1'b1;
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h1111_1111;
    step();
    i_imem_ack = 1'b0;
    chk("buf2_req", {31'd0, o_imem_req}, 32'd0);
    i_redirect_en = 1'b1;
    i_redirect_pc = 32'h200;
    step();
    i_redirect_en = 1'b0;
    i_stall       = 1'b0;
    chk("redir_buf_addr", o_imem_addr, 32'h200);
    chk("redir_buf_req", {31'd0, o_imem_req}, 32'd1);
    chk("redir_buf_valid", {31'd0, o_valid}, 32'd0);

    // Opcode sweep
    for (int j = 0; j < 8; j++) begin
      a = 32'h200 + 32'(4 * j);
      chk("sweep_addr", o_imem_addr, a);
      i_imem_ack   = 1'b1;
      i_imem_rdata = sweep_instr[j];
      push(sweep_instr[j], a, sweep_sel[j]);
      step();
    end
    i_imem_ack = 1'b0;
    step();

    // PC wrap on a block reset to the top of the address space
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    chk("wrap_req", {31'd0, req2}, 32'd1);
    ack2         = 1'b1;
    i_imem_rdata = 32'h0010_0093;
    step();
    ack2 = 1'b0;
    chk("wrap_addr1", addr2, 32'h0);
    chk("wrap_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_2, 32'h0);
    chk("wrap_valid", {31'd0, valid2}, 32'd1);

    // Asynchronous reset during a pending request
    chk("pre_rst_addr", o_imem_addr, 32'h220);
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h0070_0093;
    push(i_imem_rdata, 32'h220, 3'b011);
    step();
    i_imem_ack = 1'b0;
    #4;
    i_rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, o_valid}, 32'd0);
    chk("arst_instr", o_instr, NOP);
    chk("arst_pc", o_pc, 32'h0);
    chk("arst_pc4", o_pc4, 32'h4);
    chk("arst_req", {31'd0, o_imem_req}, 32'd0);
    chk("arst_addr", o_imem_addr, 32'h0);
    chk("arst_imm_sel", {29'd0, o_imm_sel}, 32'd7);
    step();
    step();
    i_rst_n = 1'b1;
    chk("reboot_req", {31'd0, o_imem_req}, 32'd0);
    step();
    chk("refetch_req", {31'd0, o_imem_req}, 32'd1);
    chk("refetch_addr", o_imem_addr, 32'h0);
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h0090_0093;
    push(i_imem_rdata, 32'h0, 3'b011);
    step();
    i_imem_ack = 1'b0;
    step();
    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
